wb_burst_fetch: RTL and testbench
=================================

Name: wb_burst_fetch

Overview:
- Wishbone B3 read-burst master that sits directly upstream of the on-chip RAM slave.
- Accepts read requests of 1..MAX_BEATS words on a valid/ready port and issues incrementing bursts (CTI 010, final beat CTI 111).
- Returned words go into an internal FIFO and are drained through a valid/ready response stream.
- Feeds instruction-prefetch and cache line-fill paths.

Parameters:
- AW, 32, byte address width.
- MAX_BEATS, 16, largest burst length accepted.
- FIFO_DEPTH, 16, response FIFO entries; power of 2, at least MAX_BEATS.
- LW, $clog2(MAX_BEATS+1), width of the length field.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle.
- req_adr_i  in  AW  start byte address; bits [1:0] ignored.
- req_len_i  in  LW  beat count, 1..MAX_BEATS.
- req_wrap_i  in  1  wrap burst request (see Optional Feature).
- rsp_valid_o  out  1  response word valid.
- rsp_ready_i  in  1  consumer takes the word.
- rsp_data_o  out  32  read data.
- rsp_last_o  out  1  final word of the request.
- rsp_err_o  out  1  word terminated by a bus error.
- wbm_adr_o  out  AW  bus address.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type extension.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  bus strobe.
- wbm_we_o  out  1  write enable; tied 0.
- wbm_sel_o  out  4  byte selects; tied 4'hF.
- wbm_dat_i  in  32  bus read data.
- wbm_ack_i  in  1  bus acknowledge.
- wbm_err_i  in  1  bus error.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_ni is synchronous and active-low.
- Reset values:
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_adr_o=0, wbm_cti_o=000, wbm_bte_o=00.
  - req_ready_o=0, rsp_valid_o=0, rsp_last_o=0, rsp_err_o=0.
  - FIFO empty; FSM in IDLE.
- FSM has two states, IDLE and BURST.
- IDLE:
  - req_ready_o = (FIFO free entries >= req_len_i) & req_len_i != 0. It is combinational and only asserted in IDLE.
  - On req_valid_i & req_ready_o: latch the word-aligned address, the length and the wrap flag.
  - Load beat counter = len; reserve len FIFO credits.
  - Next cycle: state BURST; cyc=stb=1.
- BURST:
  - cyc/stb held high until the final ack or an err. No wait states are inserted by the master.
  - Credit reservation at issue guarantees the FIFO never overflows mid-burst.
  - cti = 010 while counter > 1; cti = 111 when counter == 1. A single-beat request is issued with 111 from its first cycle.
  - bte = 00 (linear).
  - On each ack: push {data, last=(counter==1), err=0}; adr += 4, registered so the new address is valid the cycle after the ack; counter -= 1.
  - Ack on the last beat: cyc/stb drop the following cycle and the FSM returns to IDLE. At least 1 idle cycle is guaranteed between bursts, which restarts the slave's new-cycle detection.
  - On err: push {data=0, last=1, err=1}, abandon the remaining beats, release the unused credits, drop cyc, go to IDLE.
  - ack and err asserted together: err wins.
  - Ack while stb is low is ignored.
- Response stream:
  - rsp_* are driven from the FIFO head; pop on rsp_valid_o & rsp_ready_i.
  - Push and pop in the same cycle are legal at any occupancy, including full and empty.
  - Response latency: the first word appears on rsp_* 1 cycle after its ack (registered FIFO output).
- Address arithmetic: modulo 2^AW; wrap-around past the top of the space is silent.
- req_len_i of 0 or greater than MAX_BEATS: never accepted (req_ready_o stays 0 for that request).
- Reset mid-burst: cyc/stb drop at the reset edge, the FIFO is flushed and credits are restored. The slave sees a truncated cycle.

Optional Feature:
- Macro: WB_BURST_FETCH_WRAP_EN.
- Defined:
  - req_wrap_i=1 with len 4, 8 or 16 issues a wrap burst, bte = 01, 10 or 11 respectively.
  - The address increments by 4 modulo the line size, so the critical word comes first.
  - req_wrap_i=1 with any other length is not accepted.
- Undefined: req_wrap_i is ignored; bte is always 00 and all bursts are linear.

Decomposition:
- Package wb_burst_pkg holds:
  - CTI constants: CLASSIC 000, CONST 001, INC 010, EOB 111.
  - BTE constants: LINEAR 00, WRAP4 01, WRAP8 10, WRAP16 11.
  - FSM state typedef (IDLE, BURST).
  - Wrap-address helper function.
- One sub-module, wb_burst_fifo: synchronous FIFO, 34 bits wide (data, last, err), exposing free-entry count.

Test Plan:
- Single read: adr 0x40, len 1 -> one cycle with cti 111 and bte 00; rsp_data = mem[0x40] with last=1; cyc low after the ack.
- Linear burst: adr 0x100, len 8, slave acks every cycle -> addresses 0x100..0x11C; cti 010 x7 then 111; 8 responses, last on the 8th.
- Backpressure: rsp_ready_i=0, two requests of len 16 with FIFO_DEPTH 16 -> first accepted; second held with req_ready_o=0 until 16 pops, then issued.
- Error: len 4 at 0x200, err on beat 2 -> responses: word0 (err=0), then {err=1, last=1}; cyc drops; the next request is accepted normally.
- Reset mid-burst: wb_rst_ni low during beat 3 of 8 -> next edge cyc=0, rsp_valid_o=0, FIFO empty; a fresh len-2 request completes correctly.
- Wrap (macro defined): adr 0x108, len 4, wrap=1 -> addresses 0x108, 0x10C, 0x100, 0x104 with bte 01.

Source files
------------

// File: rtl/wb_burst_pkg.sv
// Shared constants, FSM state type and wrap-address helper for the Wishbone burst fetcher.
package wb_burst_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    // Next low address bits of a wrap burst; bits above the line size are kept.
    function automatic logic [5:0] wrap_low(input logic [5:0] lo, input logic [1:0] bte);
        logic [5:0] nxt;
        nxt = lo + 6'd4;
        case (bte)
            BTE_WRAP4:  wrap_low = {lo[5:4], nxt[3:0]};
            BTE_WRAP8:  wrap_low = {lo[5], nxt[4:0]};
            default:    wrap_low = nxt;
        endcase
    endfunction

endpackage

// File: rtl/wb_burst_fifo.sv
// Synchronous response FIFO (data, last, err) with a free-entry count for credit checks.
module wb_burst_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [W-1:0]                 data_o,
    output logic [$clog2(DEPTH+1)-1:0]   free_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i & (cnt_q != '0);
    // A push at full is still legal when the head leaves in the same cycle.
    assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_q];
    assign free_o  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/wb_burst_fetch.sv
// Wishbone B3 incrementing read-burst master with a credit-checked response FIFO.
// Optional wrap bursts are enabled by defining WB_BURST_FETCH_WRAP_EN.
module wb_burst_fetch
    import wb_burst_pkg::*;
#(
    parameter int AW         = 32,
    parameter int MAX_BEATS  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LW         = $clog2(MAX_BEATS+1)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_adr_i,
    input  logic [LW-1:0] req_len_i,
    input  logic          req_wrap_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic          rsp_last_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    input  logic [31:0]   wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i
);
    localparam int FW = $clog2(FIFO_DEPTH+1);

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d, adr_nxt;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [1:0]    bte_q, bte_d, req_bte;
    logic          wrap_ok, len_ok, last_beat, push;
    logic [33:0]   push_data, head;
    logic [FW-1:0] free;
    logic [2:0]    unused_bits;

    assign unused_bits = {req_wrap_i, req_adr_i[1:0]};
    assign last_beat   = (cnt_q == LW'(1));

    // Credits: a burst is only issued when every beat already has a FIFO slot.
    assign len_ok = (req_len_i != '0) && (32'(req_len_i) <= 32'(MAX_BEATS))
                    && (32'(free) >= 32'(req_len_i));

`ifdef WB_BURST_FETCH_WRAP_EN
    always_comb begin
        wrap_ok = 1'b1;
        req_bte = BTE_LINEAR;
        if (req_wrap_i) begin
            case (req_len_i)
                LW'(4):  req_bte = BTE_WRAP4;
                LW'(8):  req_bte = BTE_WRAP8;
                LW'(16): req_bte = BTE_WRAP16;
                default: wrap_ok = 1'b0;
            endcase
        end
    end

    assign adr_nxt = (bte_q == BTE_LINEAR) ? adr_q + AW'(4)
                                           : {adr_q[AW-1:6], wrap_low(adr_q[5:0], bte_q)};
`else
    assign wrap_ok = 1'b1;
    assign req_bte = BTE_LINEAR;
    assign adr_nxt = adr_q + AW'(4);
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        cnt_d       = cnt_q;
        bte_d       = bte_q;
        push        = 1'b0;
        push_data   = '0;
        req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = wb_rst_ni & len_ok & wrap_ok;
                if (req_valid_i && req_ready_o) begin
                    adr_d   = {req_adr_i[AW-1:2], 2'b00};
                    cnt_d   = req_len_i;
                    bte_d   = req_bte;
                    state_d = BURST;
                end
            end
            BURST: begin
                // Error beats close the response and drop all remaining credits.
                if (wbm_err_i) begin
                    push      = 1'b1;
                    push_data = {32'h0, 1'b1, 1'b1};
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (wbm_ack_i) begin
                    push      = 1'b1;
                    push_data = {wbm_dat_i, last_beat, 1'b0};
                    adr_d     = adr_nxt;
                    cnt_d     = cnt_q - LW'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            bte_q   <= BTE_LINEAR;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            bte_q   <= bte_d;
        end
    end

    assign wbm_cyc_o = (state_q == BURST);
    assign wbm_stb_o = (state_q == BURST);
    assign wbm_adr_o = adr_q;
    assign wbm_cti_o = (state_q == BURST) ? (last_beat ? CTI_EOB : CTI_INC) : CTI_CLASSIC;
    assign wbm_bte_o = (state_q == BURST) ? bte_q : BTE_LINEAR;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;

    wb_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (34)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (rsp_valid_o & rsp_ready_i),
        .valid_o (rsp_valid_o),
        .data_o  (head),
        .free_o  (free)
    );

    assign rsp_data_o = rsp_valid_o ? head[33:2] : 32'h0;
    assign rsp_last_o = rsp_valid_o & head[1];
    assign rsp_err_o  = rsp_valid_o & head[0];

endmodule

// File: tb/tb_wb_burst_fetch.sv
// Scoreboard bench for wb_burst_fetch: a zero-wait-state slave model plus bus and response checkers.
module tb_wb_burst_fetch;
    import wb_burst_pkg::*;

    localparam int AW   = 32;
    localparam int MAXB = 16;
    localparam int DEP  = 16;
    localparam int LW   = $clog2(MAXB+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_wrap;
    logic [AW-1:0] req_adr;
    logic [LW-1:0] req_len;
    logic          rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0]   rsp_data;
    logic [AW-1:0] wb_adr;
    logic [2:0]    wb_cti;
    logic [1:0]    wb_bte;
    logic          wb_cyc, wb_stb, wb_we;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat;
    logic          wb_ack, wb_err;

    wb_burst_fetch #(.AW(AW), .MAX_BEATS(MAXB), .FIFO_DEPTH(DEP), .LW(LW)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_adr_i(req_adr),
        .req_len_i(req_len), .req_wrap_i(req_wrap),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
        .wbm_adr_o(wb_adr), .wbm_cti_o(wb_cti), .wbm_bte_o(wb_bte),
        .wbm_cyc_o(wb_cyc), .wbm_stb_o(wb_stb), .wbm_we_o(wb_we), .wbm_sel_o(wb_sel),
        .wbm_dat_i(wb_dat), .wbm_ack_i(wb_ack), .wbm_err_i(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] adr; logic [2:0] cti; logic [1:0] bte; } beat_t;
    typedef struct packed { logic [31:0] data; logic last; logic err; } rsp_t;

    beat_t bus_q[$];
    rsp_t  rsp_q[$];
    beat_t e_beat;
    rsp_t  e_rsp;
    int    n_cmp = 0, n_bad = 0;
    int    pops = 0, beat_n = 0, err_at = 0, accept_pops = 0, p0 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Slave model and both checkers act on the falling edge, away from the DUT's sampling edge.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            pops++;
            if (rsp_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'(rsp_data), 64'hX);
            end else begin
                e_rsp = rsp_q.pop_front();
                check_eq("rsp_data", 64'(rsp_data), 64'(e_rsp.data));
                check_eq("rsp_last", 64'(rsp_last), 64'(e_rsp.last));
                check_eq("rsp_err",  64'(rsp_err),  64'(e_rsp.err));
            end
        end
        if (wb_cyc && wb_stb) begin
            beat_n++;
            if (bus_q.size() == 0) begin
                check_eq("bus_unexpected", 64'(wb_adr), 64'hX);
            end else begin
                e_beat = bus_q.pop_front();
                check_eq("bus_adr", 64'(wb_adr), 64'(e_beat.adr));
                check_eq("bus_cti", 64'(wb_cti), 64'(e_beat.cti));
                check_eq("bus_bte", 64'(wb_bte), 64'(e_beat.bte));
            end
            if (beat_n == err_at) begin
                wb_ack = 1'b0; wb_err = 1'b1; wb_dat = 32'hDEAD_BEEF;
            end else begin
                wb_ack = 1'b1; wb_err = 1'b0; wb_dat = memf(wb_adr);
            end
        end else begin
            beat_n = 0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat = 32'h0;
        end
    end

    task automatic send(input logic [31:0] a, input int len, input bit wrap, input bit exp_wrap,
                        input int e_at);
        logic [31:0] base, line, ad;
        logic [1:0]  bte;
        int          t;
        base = {a[31:2], 2'b00};
        line = 32'(len * 4);
        bte  = !exp_wrap ? 2'b00 : (len == 4) ? 2'b01 : (len == 8) ? 2'b10 : 2'b11;
        for (int i = 0; i < len; i++) begin
            ad = exp_wrap ? ((base & ~(line - 1)) | ((base + 32'(4*i)) & (line - 1)))
                          : base + 32'(4*i);
            if (e_at == 0 || i + 1 <= e_at)
                bus_q.push_back('{ad, (i == len-1) ? 3'b111 : 3'b010, bte});
            if (e_at == 0 || i + 1 < e_at)
                rsp_q.push_back('{memf(ad), i == len-1, 1'b0});
            else if (i + 1 == e_at)
                rsp_q.push_back('{32'h0, 1'b1, 1'b1});
        end
        err_at    = e_at;
        req_adr   = a;
        req_len   = LW'(len);
        req_wrap  = wrap;
        req_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready) begin
                accept_pops = pops;
                break;
            end
            t++;
            if (t > 400) begin
                check_eq("req_accept_timeout", 64'(req_ready), 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || wb_cyc) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_done", 64'(t < 500), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_adr = '0; req_len = LW'(1); req_wrap = 1'b0;
        rsp_ready = 1'b1; wb_ack = 1'b0; wb_err = 1'b0; wb_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cyc", 64'(wb_cyc), 64'd0);
        check_eq("rst_stb", 64'(wb_stb), 64'd0);
        check_eq("rst_adr", 64'(wb_adr), 64'd0);
        check_eq("rst_cti", 64'(wb_cti), 64'd0);
        check_eq("rst_bte", 64'(wb_bte), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_last", 64'(rsp_last), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("tie_we_sel", 64'({wb_we, wb_sel}), 64'h0F);
        rst_n = 1'b1;
        req_len = LW'(0);  #1 check_eq("len0_ready", 64'(req_ready), 64'd0);
        req_len = LW'(17); #1 check_eq("len17_ready", 64'(req_ready), 64'd0);
        req_len = LW'(16); #1 check_eq("len16_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // Single read, then cyc must fall right after the ack.
        send(32'h40, 1, 1'b0, 1'b0, 0);
        @(negedge clk); check_eq("single_cyc_on", 64'(wb_cyc), 64'd1);
        @(negedge clk); check_eq("single_cyc_off", 64'(wb_cyc), 64'd0);
        wait_idle();

        send(32'h100, 8, 1'b0, 1'b0, 0);
        wait_idle();
        send(32'hFFFF_FFFB, 4, 1'b0, 1'b0, 0);
        wait_idle();

        // Backpressure: second 16-beat request waits for all 16 pops.
        rsp_ready = 1'b0;
        send(32'h300, 16, 1'b0, 1'b0, 0);
        fork
            send(32'h400, 16, 1'b0, 1'b0, 0);
            begin
                repeat (25) @(negedge clk);
                check_eq("bp_hold_ready", 64'(req_ready), 64'd0);
                check_eq("bp_full_valid", 64'(rsp_valid), 64'd1);
                p0 = pops;
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        check_eq("bp_pops_at_accept", 64'(accept_pops - p0), 64'd16);
        wait_idle();

        send(32'h200, 4, 1'b0, 1'b0, 2);
        wait_idle();
        send(32'h240, 2, 1'b0, 1'b0, 0);
        wait_idle();

        // Reset while beat 3 of 8 is on the bus.
        rsp_ready = 1'b0;
        send(32'h600, 8, 1'b0, 1'b0, 0);
        for (int t = 0; t < 50 && beat_n != 2; t++) begin
            @(posedge clk); #1;
        end
        check_eq("rst_mid_beat", 64'(beat_n), 64'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("rstm_cyc", 64'(wb_cyc), 64'd0);
        check_eq("rstm_stb", 64'(wb_stb), 64'd0);
        check_eq("rstm_rsp_valid", 64'(rsp_valid), 64'd0);
        bus_q.delete();
        rsp_q.delete();
        rst_n = 1'b1;
        req_len = LW'(16);
        @(negedge clk);
        check_eq("rstm_fifo_empty", 64'(rsp_valid), 64'd0);
        check_eq("rstm_credits", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(32'h500, 2, 1'b0, 1'b0, 0);
        wait_idle();

`ifdef WB_BURST_FETCH_WRAP_EN
        send(32'h108, 4, 1'b1, 1'b1, 0);
        wait_idle();
        send(32'h11C, 8, 1'b1, 1'b1, 0);
        wait_idle();
        req_wrap = 1'b1; req_len = LW'(5);
        #1 check_eq("wrap_len5_ready", 64'(req_ready), 64'd0);
`else
        send(32'h108, 4, 1'b1, 1'b0, 0);
        wait_idle();
        req_wrap = 1'b1; req_len = LW'(5);
        #1 check_eq("wrap_ignored_ready", 64'(req_ready), 64'd1);
`endif
        req_wrap = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
